mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_CH, default 3, number of requester channels (2..8).
REQ-002 Parameter AW, default 13, BSRAM address width.
REQ-003 Parameter DW, default 8, data width.
REQ-004 Parameter RD_LAT, default 2, BSRAM read latency in clk cycles from mem_ce to valid mem_dout (1..3).
REQ-005 clk  input  1  single clock, BSRAM port clock (MEMORY_CLK domain).
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 req  input  NUM_CH  per-channel access request, held until granted.
REQ-008 we  input  NUM_CH  per-channel write enable, qualified by req.
REQ-009 addr  input  NUM_CH*AW  per-channel address, channel i at [i*AW +: AW].
REQ-010 wdata  input  NUM_CH*DW  per-channel write data, channel i at [i*DW +: DW].
REQ-011 gnt  output  NUM_CH  one-hot grant, combinational, same cycle as the winning req.
REQ-012 rvalid  output  NUM_CH  one-cycle pulse, read data valid for channel i.
REQ-013 rdata  output  DW  read data, shared by all channels, valid only with an rvalid bit.
REQ-014 mem_ce  output  1  BSRAM clock enable, registered.
REQ-015 mem_we  output  1  BSRAM write enable, registered.
REQ-016 mem_ad  output  AW  BSRAM address, registered.
REQ-017 mem_din  output  DW  BSRAM write data, registered.
REQ-018 mem_dout  input  DW  BSRAM read data.

Function
REQ-019 At most one gnt bit is set per cycle; gnt is all-zero when req is all-zero.
REQ-020 Arbitration is round-robin: the search starts at pointer ptr, and the winner is the first set req bit at index ptr, ptr+1, ... with wrap from NUM_CH-1 to 0.
REQ-021 After a grant to channel k, ptr becomes (k+1) mod NUM_CH on the next clk; without a grant, ptr is unchanged.
REQ-022 On the clk edge ending a grant cycle to channel k, mem_ce=1, mem_we=we[k], mem_ad=addr[k], and mem_din=wdata[k]; without a grant, mem_ce=0 and mem_we=0, while mem_ad and mem_din hold.
REQ-023 A granted read returns rvalid[k]=1 with rdata=mem_dout exactly RD_LAT cycles after its mem_ce cycle, tracked by an RD_LAT-deep valid/channel-ID shift pipeline.
REQ-024 A granted write produces no rvalid.
REQ-025 Throughput: one grant per cycle; back-to-back grants to different or identical channels are legal, and pipelined reads return in grant order.
REQ-026 A lone requester holding req continuously is granted every cycle.
REQ-027 A channel that drops req before grant is not served, and no state is retained.
REQ-028 A mem_dout value with no pipeline entry is ignored: rvalid stays all-zero.

Reset
REQ-029 While rst=1: gnt=0, rvalid=0, rdata=0, mem_ce=0, mem_we=0, mem_ad=0, mem_din=0, ptr=0.
REQ-030 Reset during outstanding reads flushes the pipeline, so no rvalid for those reads appears after rst deasserts.
REQ-031 The first grant after reset follows REQ-020 starting at channel 0.

Configuration
REQ-032 With MEM_ARB_CH0_PRIO_EN defined, channel 0 (LCD refresh) wins whenever req[0]=1, and ptr does not advance on a channel-0 grant; the remaining channels are round-robin among themselves per REQ-020/021.
REQ-033 Without MEM_ARB_CH0_PRIO_EN, all channels are pure round-robin.

Verification
REQ-034 req=3'b111 held for 6 cycles, no macro -> gnt sequence 001,010,100,001,010,100.
REQ-035 Ch1 read at addr 0x0A5 with RD_LAT=2 and memory model returning 0x5A -> mem_ce at T+1, rvalid=3'b010 with rdata=0x5A at T+3.
REQ-036 Ch2 write addr 0x1FFF, data 0xC3 -> mem_we=1, mem_ad=0x1FFF, mem_din=0xC3 at T+1, and no rvalid.
REQ-037 Reads from ch0, ch1, ch2 in consecutive cycles -> rvalid 001,010,100 in consecutive cycles with the matching data.
REQ-038 Read granted, then rst pulsed for 1 cycle before return -> rvalid stays 0, all outputs 0 during reset.
REQ-039 MEM_ARB_CH0_PRIO_EN, req=3'b111 held -> gnt=001 every cycle; req[0] dropped -> gnt 010, 100, 010.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester and BSRAM-side signal bundle for mem_arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the memory.
interface mem_arbiter_if #(
    parameter int NUM_CH = 3,
    parameter int AW     = 13,
    parameter int DW     = 8
);
    logic [NUM_CH-1:0]    req;
    logic [NUM_CH-1:0]    we;
    logic [NUM_CH*AW-1:0] addr;
    logic [NUM_CH*DW-1:0] wdata;
    logic [NUM_CH-1:0]    gnt;
    logic [NUM_CH-1:0]    rvalid;
    logic [DW-1:0]        rdata;
    logic                 mem_ce;
    logic                 mem_we;
    logic [AW-1:0]        mem_ad;
    logic [DW-1:0]        mem_din;
    logic [DW-1:0]        mem_dout;

    modport slave (
        input  req, we, addr, wdata, mem_dout,
        output gnt, rvalid, rdata, mem_ce, mem_we, mem_ad, mem_din
    );

    modport master (
        output req, we, addr, wdata, mem_dout,
        input  gnt, rvalid, rdata, mem_ce, mem_we, mem_ad, mem_din
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one BSRAM port among NUM_CH requesters, with read-return pipeline.
// Optional macro MEM_ARB_CH0_PRIO_EN: channel 0 (LCD refresh) gets absolute priority.
module mem_arbiter #(
    parameter int NUM_CH = 3,
    parameter int AW     = 13,
    parameter int DW     = 8,
    parameter int RD_LAT = 2
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam int CW = $clog2(NUM_CH);

    logic [CW-1:0]              ptr_q, ptr_d;
    logic                       mem_ce_q, mem_ce_d;
    logic                       mem_we_q, mem_we_d;
    logic [AW-1:0]              mem_ad_q, mem_ad_d;
    logic [DW-1:0]              mem_din_q, mem_din_d;
    logic [CW-1:0]              ch_q, ch_d;
    logic [RD_LAT-1:0]          rd_vld_q, rd_vld_d;
    logic [RD_LAT-1:0][CW-1:0]  rd_ch_q, rd_ch_d;

    logic                       rr_any, gnt_any;
    logic [CW-1:0]              rr_idx, gnt_idx;
    int                         rr_pos;
    logic [NUM_CH-1:0]          gnt;
    logic [NUM_CH-1:0]          rvalid;
    logic [DW-1:0]              rdata;

    // Arbitration and next-state logic.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        rr_any  = 1'b0;
        rr_idx  = '0;
        rr_pos  = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            rr_pos = (int'(ptr_q) + i) % NUM_CH;
            if (!rr_any && bus.req[rr_pos]) begin
                rr_any = 1'b1;
                rr_idx = CW'(rr_pos);
            end
        end

`ifdef MEM_ARB_CH0_PRIO_EN
        if (bus.req[0]) begin
            gnt_any = 1'b1;
            gnt_idx = '0;
        end else begin
            gnt_any = rr_any;
            gnt_idx = rr_idx;
        end
`else
        gnt_any = rr_any;
        gnt_idx = rr_idx;
`endif
        if (rst) gnt_any = 1'b0;

        gnt = '0;
        gnt[gnt_idx] = gnt_any;

        ptr_d = ptr_q;
        if (gnt_any) ptr_d = (gnt_idx == CW'(NUM_CH - 1)) ? '0 : gnt_idx + CW'(1);
`ifdef MEM_ARB_CH0_PRIO_EN
        // A channel-0 grant leaves the rotation of the other channels untouched.
        if (bus.req[0]) ptr_d = ptr_q;
`endif

        mem_ce_d  = gnt_any;
        mem_we_d  = gnt_any & bus.we[gnt_idx];
        mem_ad_d  = gnt_any ? bus.addr[int'(gnt_idx)*AW +: AW]  : mem_ad_q;
        mem_din_d = gnt_any ? bus.wdata[int'(gnt_idx)*DW +: DW] : mem_din_q;
        ch_d      = gnt_any ? gnt_idx : ch_q;

        // Stage 0 is the cycle after mem_ce; the last stage lines up with valid mem_dout.
        rd_vld_d    = rd_vld_q;
        rd_ch_d     = rd_ch_q;
        rd_vld_d[0] = mem_ce_q & ~mem_we_q;
        rd_ch_d[0]  = ch_q;
        for (int j = 1; j < RD_LAT; j++) begin
            rd_vld_d[j] = rd_vld_q[j-1];
            rd_ch_d[j]  = rd_ch_q[j-1];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            ptr_q     <= '0;
            mem_ce_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_ad_q  <= '0;
            mem_din_q <= '0;
            ch_q      <= '0;
            rd_vld_q  <= '0;
            rd_ch_q   <= '0;
        end else begin
            ptr_q     <= ptr_d;
            mem_ce_q  <= mem_ce_d;
            mem_we_q  <= mem_we_d;
            mem_ad_q  <= mem_ad_d;
            mem_din_q <= mem_din_d;
            ch_q      <= ch_d;
            rd_vld_q  <= rd_vld_d;
            rd_ch_q   <= rd_ch_d;
        end
    end

    always_comb begin
        rvalid = '0;
        rdata  = '0;
        if (!rst && rd_vld_q[RD_LAT-1]) begin
            rvalid[rd_ch_q[RD_LAT-1]] = 1'b1;
            rdata = bus.mem_dout;
        end
    end

    assign bus.gnt     = gnt;
    assign bus.rvalid  = rvalid;
    assign bus.rdata   = rdata;
    assign bus.mem_ce  = mem_ce_q;
    assign bus.mem_we  = mem_we_q;
    assign bus.mem_ad  = mem_ad_q;
    assign bus.mem_din = mem_din_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed grant checks plus a read-return scoreboard.
// Builds with or without MEM_ARB_CH0_PRIO_EN; the grant expectations follow the macro.
module tb_mem_arbiter;
    localparam int NUM_CH = 3;
    localparam int AW     = 13;
    localparam int DW     = 8;
    localparam int RD_LAT = 2;

    typedef struct {
        int         ch;
        logic [7:0] data;
        int         due;
    } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    rd_t        sb[$];
    logic [7:0] exp_mem [int];
    logic [12:0] ch_addr  [NUM_CH];
    logic [7:0]  ch_wdata [NUM_CH];
    logic [12:0] exp_ad = '0;
    logic [7:0]  exp_din = '0;

    mem_arbiter_if #(.NUM_CH(NUM_CH), .AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.NUM_CH(NUM_CH), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural BSRAM: unwritten words read as ~addr[7:0]; read data appears RD_LAT cycles after mem_ce.
    bit [7:0] bram    [0:8191];
    bit       written [0:8191];
    logic [7:0] pipe  [RD_LAT];
    always @(posedge clk) begin
        if (bus.mem_ce && bus.mem_we) begin
            bram[bus.mem_ad]    <= bus.mem_din;
            written[bus.mem_ad] <= 1'b1;
        end
        if (bus.mem_ce && !bus.mem_we)
            pipe[0] <= written[bus.mem_ad] ? bram[bus.mem_ad] : ~bus.mem_ad[7:0];
        else
            pipe[0] <= 8'hEE;
        for (int j = 1; j < RD_LAT; j++) pipe[j] <= pipe[j-1];
    end
    assign bus.mem_dout = pipe[RD_LAT-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Read-return monitor: every rvalid must match the oldest scoreboard entry, on its due cycle.
    always @(negedge clk) begin
        if (bus.rvalid != '0) begin
            if (sb.size() == 0) begin
                check("rv.spurious", 32'(bus.rvalid), 32'h0);
            end else begin
                rd_t e;
                e = sb.pop_front();
                check("rv.ch",   32'(bus.rvalid), 32'(1 << e.ch));
                check("rv.data", 32'(bus.rdata),  32'(e.data));
                check("rv.cyc",  32'(cyc),        32'(e.due));
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            rd_t e;
            e = sb.pop_front();
            check("rv.missing", 32'(bus.rvalid), 32'(1 << e.ch));
        end
    end

    task automatic drive_bus(input logic [2:0] r, input logic [2:0] w);
        bus.req = r;
        bus.we  = w;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.addr[i*AW +: AW]  = ch_addr[i];
            bus.wdata[i*DW +: DW] = ch_wdata[i];
        end
    endtask

    // One clock cycle: drive requests, check gnt mid-cycle, then check the registered memory port.
    task automatic tick(input string tag, input logic [2:0] r, input logic [2:0] w, input logic [2:0] eg);
        logic        n_ce, n_we;
        logic [12:0] n_ad;
        logic [7:0]  n_din;
        rd_t         e;
        drive_bus(r, w);
        @(negedge clk);
        check({tag, ".gnt"}, 32'(bus.gnt), 32'(eg));
        n_ce  = 1'b0;
        n_we  = 1'b0;
        n_ad  = exp_ad;
        n_din = exp_din;
        for (int k = 0; k < NUM_CH; k++) begin
            if (eg[k]) begin
                n_ce  = 1'b1;
                n_we  = w[k];
                n_ad  = ch_addr[k];
                n_din = ch_wdata[k];
                if (w[k]) begin
                    exp_mem[int'(ch_addr[k])] = ch_wdata[k];
                end else begin
                    e.ch   = k;
                    e.data = exp_mem.exists(int'(ch_addr[k])) ? exp_mem[int'(ch_addr[k])] : ~ch_addr[k][7:0];
                    e.due  = cyc + 1 + RD_LAT;
                    sb.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
        check({tag, ".mem_ce"},  32'(bus.mem_ce),  32'(n_ce));
        check({tag, ".mem_we"},  32'(bus.mem_we),  32'(n_we));
        check({tag, ".mem_ad"},  32'(bus.mem_ad),  32'(n_ad));
        check({tag, ".mem_din"}, 32'(bus.mem_din), 32'(n_din));
        exp_ad  = n_ad;
        exp_din = n_din;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick("idle", 3'b000, 3'b000, 3'b000);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, ".gnt"},    32'(bus.gnt),    32'h0);
        check({tag, ".rvalid"}, 32'(bus.rvalid), 32'h0);
        check({tag, ".rdata"},  32'(bus.rdata),  32'h0);
    endtask

    task automatic check_mem_zero(input string tag);
        check({tag, ".mem_ce"},  32'(bus.mem_ce),  32'h0);
        check({tag, ".mem_we"},  32'(bus.mem_we),  32'h0);
        check({tag, ".mem_ad"},  32'(bus.mem_ad),  32'h0);
        check({tag, ".mem_din"}, 32'(bus.mem_din), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        ch_addr  = '{13'h010, 13'h020, 13'h030};
        ch_wdata = '{8'h11, 8'h22, 8'h33};
        drive_bus(3'b111, 3'b000);

        // Reset with all channels requesting: everything stays quiet.
        @(negedge clk);
        check_outputs_zero("rst");
        check_mem_zero("rst");
        @(negedge clk);
        check_outputs_zero("rst2");
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifndef MEM_ARB_CH0_PRIO_EN
        // Full contention rotates 0,1,2 from channel 0.
        tick("rr0", 3'b111, 3'b000, 3'b001);
        tick("rr1", 3'b111, 3'b000, 3'b010);
        tick("rr2", 3'b111, 3'b000, 3'b100);
        tick("rr3", 3'b111, 3'b000, 3'b001);
        tick("rr4", 3'b111, 3'b000, 3'b010);
        tick("rr5", 3'b111, 3'b000, 3'b100);
        idle(4);
`endif

        // Single ch1 read of 0x0A5: memory returns 0x5A.
        ch_addr[1] = 13'h0A5;
        tick("rd1", 3'b010, 3'b000, 3'b010);
        idle(4);

        // Ch2 write to top of memory; no read return expected.
        ch_addr[2]  = 13'h1FFF;
        ch_wdata[2] = 8'hC3;
        tick("wr2", 3'b100, 3'b100, 3'b100);
        idle(4);

        // Back-to-back reads from ch0, ch1, ch2; ch0 reads back the word just written.
        ch_addr[0] = 13'h1FFF;
        ch_addr[2] = 13'h123;
        tick("b2b0", 3'b001, 3'b000, 3'b001);
        tick("b2b1", 3'b010, 3'b000, 3'b010);
        tick("b2b2", 3'b100, 3'b000, 3'b100);
        idle(4);

`ifdef MEM_ARB_CH0_PRIO_EN
        // Channel 0 dominates; others rotate once it drops.
        tick("pri0", 3'b111, 3'b000, 3'b001);
        tick("pri1", 3'b111, 3'b000, 3'b001);
        tick("pri2", 3'b111, 3'b000, 3'b001);
        tick("pri3", 3'b110, 3'b000, 3'b010);
        tick("pri4", 3'b110, 3'b000, 3'b100);
        tick("pri5", 3'b110, 3'b000, 3'b010);
        idle(4);
`else
        // Pointer skips idle channels, a dropped request is forgotten, a lone requester wins every cycle.
        ch_addr  = '{13'h100, 13'h101, 13'h102};
        ch_wdata = '{8'h5C, 8'hA7, 8'h3E};
        tick("skip1",  3'b110, 3'b110, 3'b010);
        tick("skip2",  3'b101, 3'b000, 3'b100);
        tick("lone0",  3'b010, 3'b010, 3'b010);
        tick("lone1",  3'b010, 3'b010, 3'b010);
        tick("lone2",  3'b010, 3'b000, 3'b010);
        tick("wrap0",  3'b011, 3'b000, 3'b001);
        tick("wrap1",  3'b011, 3'b000, 3'b010);
        idle(4);
`endif

        // Reset pulse while a read is in flight: the read must never return, and ptr restarts at 0.
        ch_addr[0] = 13'h040;
        tick("rfl", 3'b001, 3'b000, 3'b001);
        rst = 1'b1;
        drive_bus(3'b111, 3'b000);
        @(negedge clk);
        check_outputs_zero("rfl.rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_bus(3'b000, 3'b000);
        check_mem_zero("rfl.post");
        sb.delete();
        exp_ad  = '0;
        exp_din = '0;
        idle(4);
        tick("first", 3'b101, 3'b000, 3'b001);
        idle(4);

        check("sb.drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
